// File: rtl/counter_nbit.sv
// ============================================================================
// counter_nbit
// ----------------------------------------------------------------------------
// General-purpose up/down counter with a programmable terminal value.
// The counting range is 0..limit. Hitting a boundary produces a one-cycle
// terminal-count pulse (tc) and sets a sticky flag (ovf).
//
// Build option:
//   COUNTER_NBIT_SAT_EN  undefined (default) -> wrap at the boundaries
//                        defined             -> saturate at the boundaries
//
// Parameters:
//   WIDTH      counter width in bits (>= 2)
//   RESET_VAL  value of `number` while reset is held
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous, active-low reset
//   clear    synchronous clear to 0 (highest priority)
//   set      synchronous load of data_in
//   data_in  load value (may exceed limit)
//   enable   take one counting step this cycle
//   dir      0 = count up, 1 = count down
//   limit    terminal value, sampled every cycle
//   number   current count (registered)
//   tc       terminal-count pulse (registered)
//   ovf      sticky boundary flag, cleared by clear/set/reset (registered)
// ============================================================================
module counter_nbit #(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] number,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RESET_NUM = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] number_reg, number_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;

    // Boundary detection. The up boundary uses >= so that a value loaded
    // above limit is treated as already past the terminal value.
    logic up_hit;
    logic down_hit;

    assign up_hit   = (number_reg >= limit);
    assign down_hit = (number_reg == '0);

    // Value taken on a boundary event; this is the only place the two
    // build variants differ.
    logic [WIDTH-1:0] up_boundary_val;
    logic [WIDTH-1:0] down_boundary_val;

`ifdef COUNTER_NBIT_SAT_EN
    // Saturate: clamp to limit going up (pulls an over-limit load down),
    // stick at zero going down.
    assign up_boundary_val   = limit;
    assign down_boundary_val = '0;
`else
    // Wrap: roll over to the opposite end of the 0..limit range.
    assign up_boundary_val   = '0;
    assign down_boundary_val = limit;
`endif

    always_comb begin
        number_next = number_reg;
        tc_next     = 1'b0;
        ovf_next    = ovf_reg;

        if (clear) begin
            number_next = '0;
            ovf_next    = 1'b0;
        end else if (set) begin
            number_next = data_in;
            ovf_next    = 1'b0;
        end else if (enable) begin
            if (!dir) begin
                if (up_hit) begin
                    number_next = up_boundary_val;
                    tc_next     = 1'b1;
                    ovf_next    = 1'b1;
                end else begin
                    number_next = number_reg + ONE;
                end
            end else begin
                if (down_hit) begin
                    number_next = down_boundary_val;
                    tc_next     = 1'b1;
                    ovf_next    = 1'b1;
                end else begin
                    number_next = number_reg - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_reg <= RESET_NUM;
            tc_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            number_reg <= number_next;
            tc_reg     <= tc_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign number = number_reg;
    assign tc     = tc_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_counter_nbit.sv
// ============================================================================
// tb_counter_nbit
// ----------------------------------------------------------------------------
// Directed testbench for counter_nbit (WIDTH=8, RESET_VAL=5). Each scenario
// task drives its own stimulus and compares against hand-computed values.
// Expectations follow the build option COUNTER_NBIT_SAT_EN where the wrap
// and saturate variants differ.
// ============================================================================
`timescale 1ns/1ps
module tb_counter_nbit;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       set;
    logic [7:0] data_in;
    logic       enable;
    logic       dir;
    logic [7:0] limit;
    logic [7:0] number;
    logic       tc;
    logic       ovf;

    int checks;
    int failures;

    counter_nbit #(
        .WIDTH     (8),
        .RESET_VAL (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .set     (set),
        .data_in (data_in),
        .enable  (enable),
        .dir     (dir),
        .limit   (limit),
        .number  (number),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        clear   = 1'b0;
        set     = 1'b0;
        data_in = 8'd0;
        enable  = 1'b0;
        dir     = 1'b0;
        limit   = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (number !== 8'd5) begin
            $display("FAIL reset_number got=%0d want=5", number); failures++;
        end
        checks++;
        if (tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL reset_flags got tc=%b ovf=%b want tc=0 ovf=0", tc, ovf); failures++;
        end

        // Count from 5 with limit=3: already past limit, so first step is a boundary.
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
        checks++;
        if (tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL reset_first_step got tc=%b ovf=%b want tc=1 ovf=1", tc, ovf); failures++;
        end
        step();
`ifdef COUNTER_NBIT_SAT_EN
        checks++;
        if (number !== 8'd3) begin
            $display("FAIL reset_second_step got=%0d want=3", number); failures++;
        end
`else
        checks++;
        if (number !== 8'd1) begin
            $display("FAIL reset_second_step got=%0d want=1", number); failures++;
        end
`endif

        // Asynchronous reset in the middle of a clock period.
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (number !== 8'd5 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL reset_async got n=%0d tc=%b ovf=%b want n=5 tc=0 ovf=0",
                     number, tc, ovf); failures++;
        end
        step();
        rst_n = 1'b1;

        // clear beats set.
        enable  = 1'b0;
        clear   = 1'b1;
        set     = 1'b1;
        data_in = 8'd9;
        step();
        checks++;
        if (number !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL clear_over_set got n=%0d tc=%b ovf=%b want n=0 tc=0 ovf=0",
                     number, tc, ovf); failures++;
        end
        clear = 1'b0;
        set   = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_n[5];
        logic       exp_tc[5];
        logic       exp_ovf[5];
`ifdef COUNTER_NBIT_SAT_EN
        exp_n  = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_n  = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        limit  = 8'd3;
        dir    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (number !== exp_n[i] || tc !== exp_tc[i] || ovf !== exp_ovf[i]) begin
                $display("FAIL up_wrap[%0d] got n=%0d tc=%b ovf=%b want n=%0d tc=%b ovf=%b",
                         i, number, tc, ovf, exp_n[i], exp_tc[i], exp_ovf[i]); failures++;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_n[3];
        logic       exp_tc[3];
`ifdef COUNTER_NBIT_SAT_EN
        exp_n  = '{8'd0, 8'd0, 8'd0};
        exp_tc = '{1'b0, 1'b1, 1'b1};
`else
        exp_n  = '{8'd0, 8'd10, 8'd9};
        exp_tc = '{1'b0, 1'b1, 1'b0};
`endif
        limit   = 8'd10;
        set     = 1'b1;
        data_in = 8'd1;
        step();
        set = 1'b0;
        checks++;
        if (number !== 8'd1 || ovf !== 1'b0) begin
            $display("FAIL down_load got n=%0d ovf=%b want n=1 ovf=0", number, ovf); failures++;
        end
        dir    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (number !== exp_n[i] || tc !== exp_tc[i]) begin
                $display("FAIL down_wrap[%0d] got n=%0d tc=%b want n=%0d tc=%b",
                         i, number, tc, exp_n[i], exp_tc[i]); failures++;
            end
        end
        enable = 1'b0;
        dir    = 1'b0;
    endtask

    task automatic test_load_above();
        logic [7:0] exp_n[2];
        logic       exp_tc[2];
`ifdef COUNTER_NBIT_SAT_EN
        exp_n  = '{8'd4, 8'd4};
        exp_tc = '{1'b1, 1'b1};
`else
        exp_n  = '{8'd0, 8'd1};
        exp_tc = '{1'b1, 1'b0};
`endif
        limit   = 8'd4;
        set     = 1'b1;
        data_in = 8'd200;
        step();
        set = 1'b0;
        checks++;
        if (number !== 8'd200 || tc !== 1'b0) begin
            $display("FAIL load_above got n=%0d tc=%b want n=200 tc=0", number, tc); failures++;
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (number !== exp_n[i] || tc !== exp_tc[i]) begin
                $display("FAIL load_above_step[%0d] got n=%0d tc=%b want n=%0d tc=%b",
                         i, number, tc, exp_n[i], exp_tc[i]); failures++;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_saturate();
        logic [7:0] exp_up[5];
        logic       exp_up_tc[5];
        logic [7:0] exp_dn[2];
        logic       exp_dn_tc[2];
`ifdef COUNTER_NBIT_SAT_EN
        exp_up    = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
        exp_up_tc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_dn    = '{8'd0, 8'd0};
        exp_dn_tc = '{1'b1, 1'b1};
`else
        exp_up    = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        exp_up_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_dn    = '{8'd2, 8'd1};
        exp_dn_tc = '{1'b1, 1'b0};
`endif
        clear = 1'b1;
        step();
        clear  = 1'b0;
        limit  = 8'd2;
        dir    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (number !== exp_up[i] || tc !== exp_up_tc[i]) begin
                $display("FAIL limit2_up[%0d] got n=%0d tc=%b want n=%0d tc=%b",
                         i, number, tc, exp_up[i], exp_up_tc[i]); failures++;
            end
        end
        enable = 1'b0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
        dir    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (number !== exp_dn[i] || tc !== exp_dn_tc[i]) begin
                $display("FAIL limit2_down[%0d] got n=%0d tc=%b want n=%0d tc=%b",
                         i, number, tc, exp_dn[i], exp_dn_tc[i]); failures++;
            end
        end
        enable = 1'b0;
        dir    = 1'b0;
    endtask

    task automatic test_limit_zero();
        clear = 1'b1;
        step();
        clear  = 1'b0;
        limit  = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dir = (i >= 3) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (number !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
                $display("FAIL limit_zero[%0d] got n=%0d tc=%b ovf=%b want n=0 tc=1 ovf=1",
                         i, number, tc, ovf); failures++;
            end
        end
        enable = 1'b0;
        dir    = 1'b0;
    endtask

    task automatic test_full_range();
        limit   = 8'd255;
        set     = 1'b1;
        data_in = 8'd254;
        step();
        set    = 1'b0;
        enable = 1'b1;
        step();
        checks++;
        if (number !== 8'd255 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL full_to_255 got n=%0d tc=%b ovf=%b want n=255 tc=0 ovf=0",
                     number, tc, ovf); failures++;
        end
        step();
`ifdef COUNTER_NBIT_SAT_EN
        checks++;
        if (number !== 8'd255 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL full_boundary got n=%0d tc=%b ovf=%b want n=255 tc=1 ovf=1",
                     number, tc, ovf); failures++;
        end
`else
        checks++;
        if (number !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            $display("FAIL full_boundary got n=%0d tc=%b ovf=%b want n=0 tc=1 ovf=1",
                     number, tc, ovf); failures++;
        end
`endif
        enable = 1'b0;
    endtask

    task automatic test_idle();
        logic [7:0] held;
`ifdef COUNTER_NBIT_SAT_EN
        held = 8'd255;
`else
        held = 8'd0;
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (number !== held || tc !== 1'b0 || ovf !== 1'b1) begin
                $display("FAIL idle[%0d] got n=%0d tc=%b ovf=%b want n=%0d tc=0 ovf=1",
                         i, number, tc, ovf, held); failures++;
            end
        end
    endtask

    task automatic test_back_to_back();
        // set and enable together: load wins, flags clear.
        limit   = 8'd255;
        enable  = 1'b1;
        set     = 1'b1;
        data_in = 8'd7;
        step();
        checks++;
        if (number !== 8'd7 || tc !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL set_with_enable got n=%0d tc=%b ovf=%b want n=7 tc=0 ovf=0",
                     number, tc, ovf); failures++;
        end
        set = 1'b0;
        step();
        checks++;
        if (number !== 8'd8 || tc !== 1'b0) begin
            $display("FAIL step_after_set got n=%0d tc=%b want n=8 tc=0", number, tc); failures++;
        end
        // Direction flip takes effect on the very next edge.
        dir = 1'b1;
        step();
        checks++;
        if (number !== 8'd7) begin
            $display("FAIL dir_flip got n=%0d want n=7", number); failures++;
        end
        enable = 1'b0;
        dir    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_above();
        test_saturate();
        test_limit_zero();
        test_full_range();
        test_idle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
